// File: rtl/i2c_frame_slave_rx.sv
// Serial frame responder: deserialises address+data frames,
// acknowledges its own address and queues accepted bytes.
module i2c_frame_slave_rx #(
  parameter logic [3:0] MY_ADDR = 4'b0001,
  parameter int         DEPTH   = 4,
  parameter int         CW      = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          bit_en,
  input  logic          sda_in,
  output logic          ack_out,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          frame_done,
  output logic          frame_err,
  output logic          overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK,
    DATA,
    NACK,
    STOP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [2:0]  cnt;
  logic [2:0]  cnt_n;
  logic [3:0]  addr_q;
  logic [3:0]  addr_n;
  logic [7:0]  data_q;
  logic [7:0]  data_n;
  logic        match;
  logic        match_n;
  logic        stop_good;
  logic        stop_bad;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;

  // Frame sequencer: advances one field bit per strobe.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    addr_n    = addr_q;
    data_n    = data_q;
    match_n   = match;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (bit_en) begin
      unique case (state)
        IDLE: begin
          if (sda_in) begin
            state_n = ADDR;
            cnt_n   = 3'd0;
          end
        end
        ADDR: begin
          addr_n[cnt[1:0]] = sda_in;
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd3) begin
            state_n = ACK;
            match_n = ({sda_in, addr_q[2:0]} == MY_ADDR);
          end
        end
        ACK: begin
          state_n = DATA;
          cnt_n   = 3'd0;
        end
        DATA: begin
          data_n[cnt] = sda_in;
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            state_n = NACK;
          end
        end
        NACK: begin
          state_n = sda_in ? STOP : IDLE;
        end
        STOP: begin
          state_n   = IDLE;
          stop_good = sda_in;
          stop_bad  = ~sda_in;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Sequencer and shift registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      addr_q <= 4'd0;
      data_q <= 8'd0;
      match  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      data_q <= data_n;
      match  <= match_n;
    end
  end

  assign ack_out = (state == ACK) && match;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = rd_en && !empty;

  // A pop in the same cycle frees the slot the push needs.
  assign push = stop_good && match && (!full || pop);
  assign drop = stop_good && match && full && !pop;

  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  // Byte storage; stale entries are unreachable after reset.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr] <= data_q;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame outcome pulses, one cycle after the deciding bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= push;
      frame_err  <= stop_bad;
      overflow   <= drop;
    end
  end

endmodule

// File: tb/tb_i2c_frame_slave_rx.sv
// Directed bench for i2c_frame_slave_rx with a byte scoreboard
// and pulse counters sampled on the falling edge.
module tb_i2c_frame_slave_rx;

  logic       clock = 1'b0;
  logic       reset;
  logic       bit_en;
  logic       sda_in;
  logic       ack_out;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       frame_done;
  logic       frame_err;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_ovf  = 0;
  int n_ack  = 0;
  bit gaps_on = 1'b0;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  i2c_frame_slave_rx #(
    .MY_ADDR(4'b0001),
    .DEPTH(4),
    .CW(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bit_en(bit_en),
    .sda_in(sda_in),
    .ack_out(ack_out),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  // Pulse and ack-cycle counters.
  always @(negedge clock) begin
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (overflow) n_ovf++;
    if (ack_out) n_ack++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic pop);
    if (gaps_on) repeat ($urandom_range(0, 3)) tick();
    bit_en = 1'b1;
    sda_in = b;
    rd_en  = pop;
    tick();
    bit_en = 1'b0;
    sda_in = 1'b0;
    rd_en  = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [7:0] d,
                            input logic nk, input logic st,
                            input int nbits, input logic pop_stop,
                            output logic ack_at);
    logic [15:0] f;
    f = {st, nk, d, 1'b1, a, 1'b1};
    ack_at = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      send_bit(f[i], pop_stop && (i == 15));
      if (i == 4) ack_at = ack_out;
    end
  endtask

  task automatic sb_check(input string tag);
    logic [7:0] e;
    n_chk++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: observed scoreboard empty expected entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, 32'(rd_data), 32'(e));
    end
  endtask

  task automatic pop_check(input string tag);
    sb_check(tag);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, 32'(ack_out), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_pulses"}, 32'({frame_done, frame_err, overflow}), 0);
  endtask

  initial begin
    logic ack;
    int d0, e0, o0, a0;

    reset  = 1'b1;
    bit_en = 1'b0;
    sda_in = 1'b0;
    rd_en  = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Basic receive of 0xCB.
    d0 = n_done;
    exp_q.push_back(8'hCB);
    send_frame(4'h1, 8'hCB, 1'b1, 1'b1, 16, 1'b0, ack);
    check("basic_ack", 32'(ack), 1);
    check("basic_done", 32'(frame_done), 1);
    check("basic_count", 32'(count), 1);
    check("basic_empty", 32'(empty), 0);
    pop_check("basic_rd");
    check("basic_done_once", 32'(n_done - d0), 1);
    check("basic_pop_empty", 32'(empty), 1);
    check("basic_pop_count", 32'(count), 0);

    // Pop while empty.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rd_empty_count", 32'(count), 0);
    check("rd_empty_empty", 32'(empty), 1);

    // Address mismatch.
    d0 = n_done; e0 = n_err; o0 = n_ovf; a0 = n_ack;
    send_frame(4'h2, 8'hCB, 1'b1, 1'b1, 16, 1'b0, ack);
    check("mis_ack", 32'(ack), 0);
    tick();
    check("mis_ack_cycles", 32'(n_ack - a0), 0);
    check("mis_pulses", 32'((n_done - d0) + (n_err - e0) + (n_ovf - o0)), 0);
    check("mis_count", 32'(count), 0);

    // Stop bit low.
    d0 = n_done; e0 = n_err;
    send_frame(4'h1, 8'h33, 1'b1, 1'b0, 16, 1'b0, ack);
    check("err_pulse", 32'(frame_err), 1);
    tick();
    check("err_once", 32'(n_err - e0), 1);
    check("err_no_done", 32'(n_done - d0), 0);
    check("err_count", 32'(count), 0);

    // Master abort in nack slot.
    d0 = n_done; e0 = n_err; o0 = n_ovf;
    send_frame(4'h1, 8'h44, 1'b0, 1'b1, 15, 1'b0, ack);
    tick();
    check("abort_pulses", 32'((n_done - d0) + (n_err - e0) + (n_ovf - o0)), 0);
    exp_q.push_back(8'h5A);
    send_frame(4'h1, 8'h5A, 1'b1, 1'b1, 16, 1'b0, ack);
    check("after_abort_done", 32'(frame_done), 1);
    pop_check("after_abort_rd");

    // Fill to full, then overflow.
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(8'(k));
      send_frame(4'h1, 8'(k), 1'b1, 1'b1, 16, 1'b0, ack);
    end
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 4);
    send_frame(4'h1, 8'h05, 1'b1, 1'b1, 16, 1'b0, ack);
    check("ovf_pulse", 32'(overflow), 1);
    check("ovf_no_done", 32'(frame_done), 0);
    check("ovf_count", 32'(count), 4);
    for (int k = 1; k <= 4; k++) pop_check("fifo_order");
    check("drain_empty", 32'(empty), 1);

    // Push and pop together while full.
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h11 + 8'(k));
      send_frame(4'h1, 8'h11 + 8'(k), 1'b1, 1'b1, 16, 1'b0, ack);
    end
    check("simul_full", 32'(full), 1);
    sb_check("simul_head");
    exp_q.push_back(8'h15);
    send_frame(4'h1, 8'h15, 1'b1, 1'b1, 16, 1'b1, ack);
    check("simul_done", 32'(frame_done), 1);
    check("simul_no_ovf", 32'(overflow), 0);
    check("simul_count", 32'(count), 4);
    for (int k = 0; k < 4; k++) pop_check("simul_order");

    // Reset in the middle of a frame.
    exp_q.push_back(8'h77);
    send_frame(4'h1, 8'h77, 1'b1, 1'b1, 16, 1'b0, ack);
    check("pre_rst_count", 32'(count), 1);
    send_frame(4'h1, 8'hE1, 1'b1, 1'b1, 7, 1'b0, ack);
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h3C);
    send_frame(4'h1, 8'h3C, 1'b1, 1'b1, 16, 1'b0, ack);
    check("post_rst_done", 32'(frame_done), 1);
    pop_check("post_rst_rd");

    // Same traffic with random strobe gaps.
    gaps_on = 1'b1;
    d0 = n_done; e0 = n_err; a0 = n_ack;
    exp_q.push_back(8'hCB);
    send_frame(4'h1, 8'hCB, 1'b1, 1'b1, 16, 1'b0, ack);
    check("gap_ack", 32'(ack), 1);
    check("gap_done", 32'(frame_done), 1);
    check("gap_count", 32'(count), 1);
    send_frame(4'h2, 8'h99, 1'b1, 1'b1, 16, 1'b0, ack);
    check("gap_mis_ack", 32'(ack), 0);
    send_frame(4'h1, 8'h66, 1'b1, 1'b0, 16, 1'b0, ack);
    check("gap_err", 32'(frame_err), 1);
    tick();
    check("gap_done_once", 32'(n_done - d0), 1);
    check("gap_err_once", 32'(n_err - e0), 1);
    check("gap_ack_seen", 32'(n_ack - a0 > 0), 1);
    pop_check("gap_rd");
    check("gap_final_empty", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_frame_slave_rx.md
Name: i2c_frame_slave_rx

Overview:
- Responder end of the team's serial frame link: deserialises the address+data frames produced by the master-side serialiser, one bit per strobe.
- Checks the frame's address against its own address and drives an acknowledge during the ack slot.
- Validates the framing bits and pushes accepted data bytes into a small FIFO, which downstream logic drains.

Parameters:
- MY_ADDR, 4'b0001, slave address compared against the received address field.
- DEPTH, 4, FIFO depth in bytes; must be a power of 2, at least 2.
- CW, 3, count width; must equal log2(DEPTH)+1.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- bit_en  input  1  line bit strobe; sda_in sampled only on cycles with bit_en=1
- sda_in  input  1  serial line, idle low
- ack_out  output  1  slave acknowledge, high while in ACK slot on address match
- rd_en  input  1  pop FIFO head
- rd_data  output  8  FIFO head byte, valid when empty=0 (show-ahead)
- empty  output  1  FIFO empty
- full  output  1  FIFO full
- count  output  CW  bytes held
- frame_done  output  1  1-cycle pulse: frame accepted and byte pushed
- frame_err  output  1  1-cycle pulse: framing error, frame discarded
- overflow  output  1  1-cycle pulse: valid frame dropped because FIFO full

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Frame, 16 bits, in order: start(1), addr[0..3] LSB first, ack slot, data[0..7] LSB first, nack slot(1), stop(1).
- Reset values: FSM=IDLE, ack_out=0, count=0, empty=1, full=0, rd_data=0, all pulses 0. Reset mid-frame discards the partial frame. FIFO contents are lost on reset.
- FSM states: IDLE, ADDR, ACK, DATA, NACK, STOP. All transitions occur only on bit_en cycles.
- IDLE: sda_in=1 -> ADDR with bit counter=0. sda_in=0 stays in IDLE.
- ADDR: shift sda_in into addr[cnt]. After 4 bits -> ACK. Set the match flag if the assembled address equals MY_ADDR.
- ACK: ack_out=match for the entire stay in ACK. The line value is ignored. The next bit_en moves to DATA.
- DATA: shift 8 bits into data[cnt], LSB first, then -> NACK.
- NACK: sda_in=0 is a master abort: discard the frame, no error pulse, -> IDLE. sda_in=1 -> STOP.
- STOP, sda_in=1:
  - match=1 and FIFO not full: push the byte and pulse frame_done.
  - match=1 and FIFO full: pulse overflow, no push.
  - match=0: silently ignore.
  - Then -> IDLE.
- STOP, sda_in=0: pulse frame_err, no push, -> IDLE.
- Pulse timing: all pulses are asserted in the cycle after the edge that sampled the deciding bit. The push takes effect at that same edge, so count increments in the cycle frame_done is high.
- Back-to-back frames: a start bit may arrive on the very next bit_en after stop. IDLE handles this with no dead cycles.
- bit_en=0: all state is held, including ack_out.
- FIFO: circular buffer, wr/rd pointers wrap modulo DEPTH.
- rd_en while empty is ignored, and count stays 0.
- Simultaneous push and pop:
  - Not full: count unchanged.
  - Full: the pop frees space, so the push is accepted and no overflow pulse is raised.
- rd_data always reflects the current head entry. It updates in the cycle after a pop.

Test Plan:
- Basic receive: after reset, MY_ADDR=1, send bits 1, 1,0,0,0, 1, 1,1,0,1,0,0,1,1, 1, 1 (data 0xCB) -> ack_out=1 during the ACK slot, frame_done pulses once, count=1, rd_data=0xCB, empty=0. Then rd_en for 1 cycle -> empty=1, count=0.
- Address mismatch: same frame with addr 0010 -> ack_out stays 0; no frame_done, no frame_err, no overflow; count=0.
- Framing error and abort:
  - Stop bit 0 -> frame_err pulses once, count unchanged.
  - Separate frame with nack slot 0 -> no pulses, FSM returns to IDLE.
  - A following valid 0x5A frame is received correctly.
- FIFO full/overflow:
  - Push 0x01..0x04 -> full=1, count=4.
  - Fifth frame 0x05 -> overflow pulse, count=4.
  - Pops return 0x01..0x04 in order, with pointer wrap correct.
- Simultaneous push/pop when full: hold rd_en=1 in the stop-sample cycle -> frame_done=1, no overflow, count stays 4, and the byte is read back last.
- Reset mid-frame and strobe gaps:
  - Assert reset after 7 bits -> all outputs return to reset values. A fresh frame 0x3C is then received.
  - Insert random bit_en=0 gaps -> identical results.
